instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the core's immediate generator: packs opcode, register fields, funct fields
//  and an immediate into one 32-bit RV32I instruction word.
//  Used by the self-test program builder and by the boot-patch path to synthesise
//  instructions that the decode stage then consumes.
//  Valid/ready input, valid/ready output, small output FIFO; throughput 1 instr/cycle.
// PARAMETERS
//  DEPTH      2             output FIFO entries; power of two, >= 2
//  NOP_INSTR  32'h00000013  word emitted in place of an illegal or rejected request (addi x0,x0,0)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   request valid
//  in_ready   out  1   encoder can accept; depends only on FIFO state (no out_ready path)
//  in_opcode  in   7   instr[6:0]; selects the format
//  in_rd      in   5   instr[11:7]   (R/I/U/J only)
//  in_rs1     in   5   instr[19:15]  (R/I/S/B only)
//  in_rs2     in   5   instr[24:20]  (R/S/B only)
//  in_funct3  in   3   instr[14:12]  (R/I/S/B only)
//  in_funct7  in   7   instr[31:25]  (R only)
//  in_imm     in   32  immediate, in the immediate generator's units (see BEHAVIOUR)
//  out_valid  out  1   FIFO head valid
//  out_ready  in   1   consumer accepts head
//  out_instr  out  32  encoded instruction at FIFO head
//  out_err    out  1   head entry was rejected; out_instr is NOP_INSTR
// BEHAVIOUR
//  Format decode from in_opcode:
//   - I = 0000011/0010011/1100111; S = 0100011; B = 1100011; J = 1101111.
//   - U = 0010111/0110111; R = 0110011; any other opcode is illegal.
//  Immediate units, chosen so a word decodes back to in_imm:
//   - I and S: byte value, signed 12-bit.
//   - B: halfword offset, signed 12-bit.
//   - J: halfword offset, signed 20-bit.
//   - U: right-aligned 20-bit field.
//  Bit packing (fields unused by a format are forced to 0):
//   - I: [31:20]=imm[11:0].
//   - S: [31:25]=imm[11:5]; [11:7]=imm[4:0].
//   - B: [31]=imm[11]; [30:25]=imm[9:4]; [11:8]=imm[3:0]; [7]=imm[10].
//   - J: [31]=imm[19]; [30:21]=imm[9:0]; [20]=imm[10]; [19:12]=imm[18:11].
//   - U: [31:12]=imm[19:0].
//   - R: in_imm is ignored.
//  Handshake:
//   - Accept when in_valid && in_ready; pop when out_valid && out_ready.
//   - The word is encoded combinationally and written at the accept edge.
//   - Latency is 1 cycle: out_valid rises the cycle after an accept into an empty FIFO.
//  FIFO rules:
//   - in_ready = (count != DEPTH).
//   - Full with out_ready=1: the pop completes this cycle, but in_ready stays low until next cycle.
//   - Push and pop in the same cycle: count is unchanged and order is preserved.
//   - Read and write pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//   - Pop on empty and push on full are impossible by the handshake.
//  Illegal opcode: entry = {NOP_INSTR, err=1}; the handshake proceeds normally.
//  Reset (asynchronous, also mid-transfer):
//   - count, pointers and all storage clear to 0; in-flight entries are discarded.
//   - out_valid=0, out_instr=0, out_err=0; in_ready=1 after reset.
// CONFIGURATION
//  ENC_RANGE_CHECK_EN defined:
//   - Range check: I/S/B require in_imm[31:11] all equal; J/U require in_imm[31:19] all equal.
//   - A violation stores {NOP_INSTR, err=1}.
//  ENC_RANGE_CHECK_EN undefined:
//   - High immediate bits are silently truncated.
//   - out_err is set only for illegal opcodes.
// TESTING
//  1 addi: op=0010011 rd=1 rs1=0 f3=0 imm=5 -> out_instr=0x00500093, out_err=0, one cycle after accept.
//  2 sw: op=0100011 rs1=1 rs2=2 f3=010 imm=8 -> 0x0020A423; jal: op=1101111 rd=1 imm=0x800 -> 0x000010EF.
//  3 beq: op=1100011 rs1=rs2=0 f3=0 imm=0xFFFFFFFE -> 0xFE000EE3; feeding it to the immediate generator returns 0xFFFFFFFE.
//  4 Range: addi rd=1 imm=2048 -> with _EN: 0x00000013, err=1; without: 0x80000093, err=0. op=1111111 -> NOP, err=1 in both builds.
//  5 Backpressure (DEPTH=2): out_ready=0, 3 requests -> in_ready=0 after 2 accepts.
//     Then out_ready=1: words drain in order; steady push+pop at count=1 holds count at 1.
//  6 Reset with 2 entries queued: assert rst mid-cycle -> out_valid=0 immediately.
//     After release: in_ready=1, no stale word is emitted.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a small valid/ready output FIFO.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD} fmt_e;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  fmt_e        fmt;
  logic        range_ok;
  logic [31:0] enc_word;
  entry_t      enc_entry;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    fmt = FMT_BAD;
    case (in_opcode)
      7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b1101111:                         fmt = FMT_J;
      7'b0010111, 7'b0110111:             fmt = FMT_U;
      7'b0110011:                         fmt = FMT_R;
      default:                            fmt = FMT_BAD;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Immediate must be representable after sign extension from the format's top bit.
  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S, FMT_B: range_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      FMT_J, FMT_U:        range_ok = (&in_imm[31:19]) | ~(|in_imm[31:19]);
      default:             range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:20];

  always_comb begin
    enc_word = '0;
    case (fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc_word = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                         in_imm[3:0], in_imm[10], in_opcode};
      FMT_J: enc_word = {in_imm[19], in_imm[9:0], in_imm[10], in_imm[18:11], in_rd, in_opcode};
      FMT_U: enc_word = {in_imm[19:0], in_rd, in_opcode};
      default: enc_word = NOP_INSTR;
    endcase

    if (fmt == FMT_BAD || !range_ok) begin
      enc_entry.err   = 1'b1;
      enc_entry.instr = NOP_INSTR;
    end else begin
      enc_entry.err   = 1'b0;
      enc_entry.instr = enc_word;
    end
  end

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  // in_ready looks only at the registered count, so a pop never opens a slot in the same cycle.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = mem_q[rd_ptr_q].instr;
  assign out_err   = mem_q[rd_ptr_q].err;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = enc_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is reset too, so out_instr/out_err read as 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, backpressure and reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  instr_encoder #(.DEPTH(DEPTH), .NOP_INSTR(32'h00000013)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[11];
  logic [32:0] sb[$];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    end
  endtask

  // Reference encoder: field placement by shift/mask arithmetic, range by signed bounds.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
    int          v = $signed(imm);
    logic [31:0] w;
    logic [31:0] regs_r;
    bit          narrow_bad = (v < -2048) || (v > 2047);
    bit          wide_bad   = (v < -(1 << 19)) || (v > (1 << 19) - 1);
    bit          bad = 1'b0;
    regs_r = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (op)
      7'h03, 7'h13, 7'h67: begin
        w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        bad = narrow_bad;
      end
      7'h23: begin
        w = (((imm >> 5) & 32'h7F) << 25) | regs_r | ((imm & 32'h1F) << 7);
        bad = narrow_bad;
      end
      7'h63: begin
        w = (((imm >> 11) & 32'h1) << 31) | (((imm >> 4) & 32'h3F) << 25) | regs_r |
            ((imm & 32'hF) << 8) | (((imm >> 10) & 32'h1) << 7);
        bad = narrow_bad;
      end
      7'h6F: begin
        w = (((imm >> 19) & 32'h1) << 31) | ((imm & 32'h3FF) << 21) | (((imm >> 10) & 32'h1) << 20) |
            (((imm >> 11) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
        bad = wide_bad;
      end
      7'h17, 7'h37: begin
        w = ((imm & 32'hFFFFF) << 12) | (32'(rd) << 7) | 32'(op);
        bad = wide_bad;
      end
      7'h33: begin
        w = (32'(f7) << 25) | regs_r | (32'(rd) << 7);
      end
      default: return {1'b1, 32'h00000013};
    endcase
`ifdef ENC_RANGE_CHECK_EN
    if (bad) return {1'b1, 32'h00000013};
`else
    bad = 1'b0;
`endif
    return {1'b0, w};
  endfunction

  function automatic logic [32:0] model_cur();
    return model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
  endfunction

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // One request into an empty FIFO: accepted at the next edge, visible one cycle later, then popped.
  task automatic send_one(input int i);
    drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", i), {32'd0, in_ready}, 33'd1);
    check($sformatf("vec%0d_empty_before", i), {32'd0, out_valid}, 33'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check($sformatf("vec%0d_out_valid", i), {32'd0, out_valid}, 33'd1);
    check($sformatf("vec%0d_word", i), {out_err, out_instr}, {vecs[i].exp_err, vecs[i].exp_instr});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("vec%0d_drained", i), {32'd0, out_valid}, 33'd0);
  endtask

  task automatic rand_req();
    logic [6:0]  ops[13] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h17, 7'h37, 7'h33,
                             7'h7F, 7'h00, 7'h0B, 7'h0F};
    logic [31:0] edges[8] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF,
                              32'h0007FFFF, 32'h00080000, 32'hFFF80000, 32'hFFF7FFFF};
    logic [31:0] imm;
    case ($urandom_range(0, 3))
      0:       imm = $urandom;
      1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       imm = 32'($urandom_range(0, (1 << 20) - 1)) - 32'(1 << 19);
      default: imm = edges[$urandom_range(0, 7)];
    endcase
    drive(ops[$urandom_range(0, 12)], 5'($urandom), 5'($urandom), 5'($urandom),
          3'($urandom), 7'($urandom), imm);
  endtask

  // One cycle of scoreboard-driven traffic; decisions come from the model queue, not the DUT.
  task automatic step();
    bit do_push, do_pop;
    logic [32:0] exp;
    @(negedge clk);
    check("rnd_in_ready", {32'd0, in_ready}, {32'd0, sb.size() != DEPTH});
    check("rnd_out_valid", {32'd0, out_valid}, {32'd0, sb.size() != 0});
    do_push = in_valid && (sb.size() != DEPTH);
    do_pop  = out_ready && (sb.size() != 0);
    if (do_pop) begin
      exp = sb.pop_front();
      check("rnd_word", {out_err, out_instr}, exp);
    end
    if (do_push) sb.push_back(model_cur());
    @(posedge clk); #1;
  endtask

  logic [32:0] exp_a, exp_b, exp_c, exp_d;

  initial begin
    //               op      rd  rs1 rs2 f3    f7        imm           instr         err
    vecs[0]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd5,        32'h00500093, 1'b0};
    vecs[1]  = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,  32'd8,        32'h0020A423, 1'b0};
    vecs[2]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'h800,      32'h000010EF, 1'b0};
    vecs[3]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFFFFFFE, 32'hFE000EE3, 1'b0};
`ifdef ENC_RANGE_CHECK_EN
    vecs[4]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd2048,     32'h00000013, 1'b1};
`else
    vecs[4]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd2048,     32'h80000093, 1'b0};
`endif
    vecs[5]  = '{7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 7'd5,  32'd7,        32'h00000013, 1'b1};
    vecs[6]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 1'b0};
    vecs[7]  = '{7'h37, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h12345,  32'h123452B7, 1'b0};
    vecs[8]  = '{7'h13, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFF800, 32'h80000093, 1'b0};
    vecs[9]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,  32'd2047,     32'h7FF00093, 1'b0};
    vecs[10] = '{7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,  32'd0,        32'h00000013, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", {32'd0, in_ready}, 33'd1);
    check("rst_out_valid", {32'd0, out_valid}, 33'd0);
    check("rst_word", {out_err, out_instr}, 33'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) send_one(i);

    // Backpressure: two accepts fill the FIFO, the third request waits.
    out_ready = 1'b0;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd11); exp_a = model_cur(); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd22); exp_b = model_cur();
    @(posedge clk); #1;
    drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd33); exp_c = model_cur();
    @(negedge clk);
    check("bp_full_in_ready", {32'd0, in_ready}, 33'd0);
    check("bp_head_a", {out_err, out_instr}, exp_a);
    @(posedge clk); #1;
    check("bp_hold_in_ready", {32'd0, in_ready}, 33'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_full_pop_in_ready", {32'd0, in_ready}, 33'd0);
    @(posedge clk); #1;
    check("bp_after_pop_in_ready", {32'd0, in_ready}, 33'd1);
    check("bp_head_b", {out_err, out_instr}, exp_b);
    @(posedge clk); #1;
    check("bp_head_c", {out_err, out_instr}, exp_c);
    for (int k = 0; k < 4; k++) begin
      drive(7'h13, 5'(k + 4), 5'd0, 5'd0, 3'd0, 7'd0, 32'(100 + k)); exp_d = model_cur();
      @(posedge clk); #1;
      check($sformatf("steady%0d_valid", k), {32'd0, out_valid}, 33'd1);
      check($sformatf("steady%0d_in_ready", k), {32'd0, in_ready}, 33'd1);
      check($sformatf("steady%0d_head", k), {out_err, out_instr}, exp_d);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_drained", {32'd0, out_valid}, 33'd0);

    // Reset mid-cycle with two entries queued.
    out_ready = 1'b0;
    drive(7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd99); in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    check("pre_rst_full", {32'd0, in_ready}, 33'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {32'd0, out_valid}, 33'd0);
    check("mid_rst_word", {out_err, out_instr}, 33'd0);
    check("mid_rst_in_ready", {32'd0, in_ready}, 33'd1);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_no_stale", k), {32'd0, out_valid}, 33'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic against the model queue.
    sb.delete();
    for (int n = 0; n < 500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_req();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
